// File: rtl/iter_seq_pkg.sv
// iter_seq_pkg: shared state encoding and default iteration count for iter_seq_ctrl
package iter_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, SHIFT, DONE} state_t;
  localparam int N_ITER_DEF = 4;
endpackage

// File: rtl/contador4bit.sv
// contador4bit: 4-bit up counter with synchronous clear (rst) and count enable (en)
module contador4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] Q
);
  always_ff @(posedge clk)
    if (rst) Q <= 4'd0;
    else if (en) Q <= Q + 4'd1;
endmodule

// File: rtl/iter_seq_ctrl.sv
// iter_seq_ctrl: shift-and-add sequencer (LOAD, N_ITER x {EXEC, SHIFT}, DONE) with abort
//   in:  clk, rst (sync, active-high), start, abort, lsb (multiplier LSB)
//   out: ready, busy, load, add_en, shift_en, done, iter (completed iterations)
module iter_seq_ctrl
  import iter_seq_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       lsb,
  output logic       ready,
  output logic       busy,
  output logic       load,
  output logic       add_en,
  output logic       shift_en,
  output logic       done,
  output logic [3:0] iter
);
  state_t state, state_n;
  logic lsb_q;
  logic abort_hit;
  // lsb is registered so add_en is decoded purely from flops, never from the input pin
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      lsb_q <= 1'b0;
    end else begin
      state <= state_n;
      lsb_q <= lsb;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = abort ? IDLE : EXEC;
      EXEC:    state_n = abort ? IDLE : SHIFT;
      SHIFT:   state_n = abort ? IDLE : (iter == 4'(N_ITER - 1) ? DONE : EXEC);
      default: state_n = IDLE;
    endcase
  end
  assign abort_hit = abort & busy;
  contador4bit u_cnt (
    .clk (clk),
    .rst (rst | (state == LOAD) | abort_hit),
    .en  (state == SHIFT),
    .Q   (iter)
  );
  assign ready    = state == IDLE;
  assign busy     = (state == LOAD) | (state == EXEC) | (state == SHIFT);
  assign load     = state == LOAD;
  assign add_en   = (state == EXEC) & lsb_q;
  assign shift_en = state == SHIFT;
  assign done     = state == DONE;
endmodule

// File: tb/tb_iter_seq_ctrl.sv
// tb_iter_seq_ctrl: vector table, corner sequences and random run against an offset-based model
module tb_iter_seq_ctrl;
  localparam int NI = 4;
  logic clk = 1'b0;
  logic rst, start, abort, lsb, start1, abort1, lsb1;
  logic ready, busy, load, add_en, shift_en, done;
  logic ready1, busy1, load1, add_en1, shift_en1, done1;
  logic [3:0] iter, iter1;
  logic [9:0] o, o1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  iter_seq_ctrl #(.N_ITER(NI)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lsb(lsb),
    .ready(ready), .busy(busy), .load(load), .add_en(add_en),
    .shift_en(shift_en), .done(done), .iter(iter)
  );
  iter_seq_ctrl #(.N_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .lsb(lsb1),
    .ready(ready1), .busy(busy1), .load(load1), .add_en(add_en1),
    .shift_en(shift_en1), .done(done1), .iter(iter1)
  );
  assign o  = {ready, busy, load, add_en, shift_en, done, iter};
  assign o1 = {ready1, busy1, load1, add_en1, shift_en1, done1, iter1};
  typedef struct {
    logic s, a, l, r;
    logic [9:0] e;
  } vec_t;
  vec_t tbl[17];
  // reference model: an operation is tracked as an offset d from its LOAD cycle
  bit act = 0;
  int d = 0, held = 0;
  bit add_q = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step(input logic s, input logic a, input logic l, input logic r);
    start = s; abort = a; lsb = l; rst = r;
    @(posedge clk);
    #1;
  endtask
  task automatic model_edge(input logic s, input logic a, input logic l, input logic r);
    if (r) begin
      act = 0; held = 0;
    end else if (!act) begin
      if (s) begin act = 1; d = 0; end
    end else if (a && d <= 2 * NI) begin
      act = 0; held = 0;
    end else if (d == 2 * NI + 1) begin
      act = 0; held = NI;
    end else begin
      d++;
      if (d % 2 == 1) add_q = l;
    end
  endtask
  function automatic logic [9:0] model_out();
    if (!act) return {1'b1, 5'b0, 4'(held)};
    if (d == 0) return {3'b011, 3'b000, 4'(held)};
    if (d == 2 * NI + 1) return {6'b000001, 4'(NI)};
    if (d % 2 == 1) return {3'b010, add_q, 2'b00, 4'((d - 1) / 2)};
    return {5'b01001, 1'b0, 4'((d - 1) / 2)};
  endfunction
  initial begin
    int dc, nl, nd, l2;
    logic s, a, l, r;
    start1 = 0; abort1 = 0; lsb1 = 0;
    tbl[0]  = '{0, 0, 0, 1, 10'b1000000000};
    tbl[1]  = '{0, 1, 0, 0, 10'b1000000000};
    tbl[2]  = '{0, 0, 1, 0, 10'b1000000000};
    tbl[3]  = '{0, 0, 0, 0, 10'b1000000000};
    tbl[4]  = '{1, 0, 0, 0, 10'b0110000000};
    tbl[5]  = '{0, 0, 1, 0, 10'b0101000000};
    tbl[6]  = '{0, 0, 0, 0, 10'b0100100000};
    tbl[7]  = '{0, 0, 0, 0, 10'b0100000001};
    tbl[8]  = '{1, 0, 0, 0, 10'b0100100001};
    tbl[9]  = '{0, 0, 1, 0, 10'b0101000010};
    tbl[10] = '{0, 0, 0, 0, 10'b0100100010};
    tbl[11] = '{0, 0, 1, 0, 10'b0101000011};
    tbl[12] = '{0, 0, 0, 0, 10'b0100100011};
    tbl[13] = '{0, 0, 0, 0, 10'b0000010100};
    tbl[14] = '{0, 1, 0, 0, 10'b1000000100};
    tbl[15] = '{1, 1, 0, 0, 10'b0110000100};
    tbl[16] = '{0, 1, 0, 0, 10'b1000000000};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d", i), 32'(o), 32'(tbl[i].e));
    end
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("shift2", 32'(o), 32'(10'b0100100001));
    step(0, 1, 0, 0);
    chk("abort_shift", 32'(o), 32'(10'b1000000000));
    step(1, 0, 0, 0);
    dc = 0;
    for (int i = 2; i <= 14; i++) begin
      step(0, 0, 0, 0);
      if (done && dc == 0) dc = i;
    end
    chk("restart_done_cycle", 32'(dc), 32'd10);
    nl = 0; nd = 0; l2 = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0, 0);
      if (load) begin nl++; if (nl == 2) l2 = i; end
      if (done) nd++;
    end
    chk("held_loads", 32'(nl), 32'd2);
    chk("held_dones", 32'(nd), 32'd1);
    chk("held_second_load", 32'(l2), 32'd12);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("rst_pre_exec", 32'(o), 32'(10'b0101000000));
    step(1, 0, 0, 1);
    chk("rst_in_exec", 32'(o), 32'(10'b1000000000));
    step(1, 0, 0, 0);
    chk("start_after_rst", 32'(o), 32'(10'b0110000000));
    step(0, 1, 0, 0);
    start1 = 1;
    step(0, 0, 0, 0);
    start1 = 0;
    chk("n1_load", 32'(o1), 32'(10'b0110000000));
    lsb1 = 1;
    step(0, 0, 0, 0);
    lsb1 = 0;
    chk("n1_exec", 32'(o1), 32'(10'b0101000000));
    step(0, 0, 0, 0);
    chk("n1_shift", 32'(o1), 32'(10'b0100100000));
    step(0, 0, 0, 0);
    chk("n1_done", 32'(o1), 32'(10'b0000010001));
    step(0, 0, 0, 0);
    chk("n1_idle", 32'(o1), 32'(10'b1000000001));
    model_edge(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rand_reset", 32'(o), 32'(model_out()));
    for (int i = 0; i < 600; i++) begin
      s = $urandom_range(0, 9) < 4;
      a = $urandom_range(0, 19) == 0;
      l = 1'($urandom);
      r = $urandom_range(0, 49) == 0;
      model_edge(s, a, l, r);
      step(s, a, l, r);
      chk("rand", 32'(o), 32'(model_out()));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iter_seq_ctrl.md
ITER_SEQ_CTRL -- requirements
Module: iter_seq_ctrl

Interface
REQ-001 Parameter N_ITER, default 4, iteration count per operation; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 abort  input  1  cancels a running operation; ignored in IDLE.
REQ-006 lsb  input  1  current multiplier LSB from the datapath; selects add in EXEC.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 busy  output  1  high in LOAD, EXEC, SHIFT.
REQ-009 load  output  1  datapath operand load strobe.
REQ-010 add_en  output  1  datapath accumulate strobe.
REQ-011 shift_en  output  1  datapath shift strobe.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 iter  output  4  completed-iteration count, from the internal iteration counter.

Function
REQ-014 States SHALL be IDLE, LOAD, EXEC, SHIFT, DONE; all outputs SHALL be Moore-decoded from state and counter, with no combinational path from any input to any output.
REQ-015 IDLE: ready=1; start=1 -> LOAD next cycle; otherwise stay in IDLE.
REQ-016 LOAD: load=1 for exactly one cycle; iteration counter cleared to 0 on that edge; -> EXEC.
REQ-017 EXEC: add_en = lsb as registered into state; -> SHIFT unconditionally.
REQ-018 SHIFT: shift_en=1; counter increments by 1 on that edge; if iter == N_ITER-1 -> DONE, else -> EXEC.
REQ-019 DONE: done=1, busy=0, ready=0 for one cycle; -> IDLE.
REQ-020 Latency: start high at edge k in IDLE -> load high in cycle k+1 -> done high in cycle k+2+2*N_ITER (cycle k+10 for N_ITER=4).
REQ-021 start while not in IDLE SHALL be ignored; no queueing.
REQ-022 abort in LOAD, EXEC, or SHIFT -> IDLE next cycle; counter cleared; done never asserted for the aborted operation.
REQ-023 abort in DONE SHALL be ignored; done still completes.
REQ-024 start and abort both high in IDLE -> start accepted.
REQ-025 iter SHALL never exceed N_ITER; no wrap in normal operation; value held in DONE; cleared in LOAD, on abort, and on reset.
REQ-026 At most one of load, add_en, shift_en, done SHALL be high in any cycle.

Reset
REQ-027 rst=1 at an edge -> state IDLE and counter 0 after that edge; rst has priority over start and abort.
REQ-028 Values after reset: ready=1, busy=0, load=0, add_en=0, shift_en=0, done=0, iter=0.
REQ-029 Reset mid-operation SHALL discard the operation with no done pulse; the next start behaves as from power-up.

Structure
REQ-030 Package iter_seq_pkg SHALL hold the state enum typedef (3-bit encoding) and the default N_ITER constant.
REQ-031 Iteration counting SHALL reuse the team's existing 4-bit counter contador4bit (clk, rst, en, Q), with en = (state==SHIFT) and rst = rst | (state==LOAD) | abort-taken.
REQ-032 The FSM SHALL be one state register plus a combinational next-state/output block in iter_seq_ctrl; no other sub-modules.

Verification
REQ-033 Reset then idle 3 cycles -> ready=1, iter=0, all strobes 0.
REQ-034 N_ITER=4, start pulse, lsb pattern 1,0,1,1 -> load in cycle 1; add_en in EXEC cycles 2,6,8 only; shift_en in cycles 3,5,7,9; iter reads 4 in DONE; done in cycle 10 only; ready=1 in cycle 11.
REQ-035 start held high continuously for 20 cycles -> back-to-back operations, with a new LOAD exactly one cycle after each DONE's return to IDLE and no start captured while busy.
REQ-036 abort in the second SHIFT -> IDLE next cycle, iter=0, no done pulse; a following start completes normally.
REQ-037 rst asserted in EXEC with start high -> IDLE after the edge with all outputs at reset values; start is then accepted one cycle after rst deasserts.
REQ-038 N_ITER=1 -> sequence LOAD, EXEC, SHIFT, DONE; done in cycle 4 after start.
